// File: rtl/cc_miss_refill.sv
// Cache miss refill stage: fetches a 64-byte line as an 8-beat read burst, writes it
// into the tag/data SRAMs and returns the requested word to the CPU response path.
module cc_miss_refill #(
   parameter int unsigned LINE_BEATS = 8,
   parameter int unsigned BEAT_W     = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           miss_i,
   input  logic [16:0]                    tag_i,
   input  logic [8:0]                     index_i,
   input  logic [5:0]                     offset_i,
   output logic                           busy_o,
   output logic                           mem_arvalid_o,
   input  logic                           mem_arready_i,
   output logic [31:0]                    mem_araddr_o,
   output logic [3:0]                     mem_arlen_o,
   input  logic                           mem_rvalid_i,
   output logic                           mem_rready_o,
   input  logic [BEAT_W-1:0]              mem_rdata_i,
   input  logic                           mem_rlast_i,
   output logic                           wren_tag_o,
   output logic [8:0]                     waddr_tag_o,
   output logic [17:0]                    wdata_tag_o,
   output logic                           wren_data_o,
   output logic [8:0]                     waddr_data_o,
   output logic [LINE_BEATS*BEAT_W-1:0]   wdata_data_o,
   output logic                           serve_valid_o,
   output logic [BEAT_W-1:0]              serve_data_o,
   input  logic                           serve_ready_i,
   output logic                           protocol_err_o
);

   localparam logic [2:0] LastBeat = 3'(LINE_BEATS - 1);

   typedef enum logic [2:0] {StIdle, StReq, StFill, StWrite, StServe} state_e;

   state_e                          state_q, state_d;
   logic [16:0]                     tag_q, tag_d;
   logic [8:0]                      index_q, index_d;
   logic [2:0]                      word_q, word_d;
   logic [2:0]                      beat_cnt_q, beat_cnt_d;
   logic [LINE_BEATS*BEAT_W-1:0]    line_q, line_d;
   logic                            busy_q, busy_d;
   logic                            arvalid_q, arvalid_d;
   logic [31:0]                     araddr_q, araddr_d;
   logic                            rready_q, rready_d;
   logic                            wren_q, wren_d;
   logic [8:0]                      waddr_q, waddr_d;
   logic [17:0]                     wtag_q, wtag_d;
   logic                            serve_valid_q, serve_valid_d;
   logic [BEAT_W-1:0]               serve_data_q, serve_data_d;
   logic                            err_q, err_d;

   // Byte-within-word bits of the offset play no part in selecting the served word.
   logic unused_offset;
   assign unused_offset = ^offset_i[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q         <= '0;
         index_q       <= '0;
         word_q        <= '0;
         beat_cnt_q    <= '0;
         line_q        <= '0;
         busy_q        <= 1'b0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         rready_q      <= 1'b0;
         wren_q        <= 1'b0;
         waddr_q       <= '0;
         wtag_q        <= '0;
         serve_valid_q <= 1'b0;
         serve_data_q  <= '0;
         err_q         <= 1'b0;
      end else begin
         tag_q         <= tag_d;
         index_q       <= index_d;
         word_q        <= word_d;
         beat_cnt_q    <= beat_cnt_d;
         line_q        <= line_d;
         busy_q        <= busy_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         rready_q      <= rready_d;
         wren_q        <= wren_d;
         waddr_q       <= waddr_d;
         wtag_q        <= wtag_d;
         serve_valid_q <= serve_valid_d;
         serve_data_q  <= serve_data_d;
         err_q         <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      tag_d         = tag_q;
      index_d       = index_q;
      word_d        = word_q;
      beat_cnt_d    = beat_cnt_q;
      line_d        = line_q;
      busy_d        = busy_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      rready_d      = rready_q;
      wren_d        = 1'b0;
      waddr_d       = waddr_q;
      wtag_d        = wtag_q;
      serve_valid_d = serve_valid_q;
      serve_data_d  = serve_data_q;
      err_d         = err_q;

      unique case (state_q)
         StIdle: begin
            if (miss_i) begin
               tag_d      = tag_i;
               index_d    = index_i;
               word_d     = offset_i[5:3];
               beat_cnt_d = '0;
               araddr_d   = {tag_i, index_i, 6'b0};
               arvalid_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = StReq;
            end
         end
         StReq: begin
            if (arvalid_q && mem_arready_i) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StFill;
            end
         end
         StFill: begin
            if (mem_rvalid_i && rready_q) begin
               line_d[beat_cnt_q*BEAT_W +: BEAT_W] = mem_rdata_i;
               if (beat_cnt_q == word_q) begin
                  serve_data_d = mem_rdata_i;
               end
               // Beat count alone ends the burst; rlast is only cross-checked.
               if (mem_rlast_i != (beat_cnt_q == LastBeat)) begin
                  err_d = 1'b1;
               end
               if (beat_cnt_q == LastBeat) begin
                  beat_cnt_d = '0;
                  rready_d   = 1'b0;
                  wren_d     = 1'b1;
                  waddr_d    = index_q;
                  wtag_d     = {1'b1, tag_q};
                  state_d    = StWrite;
               end else begin
                  beat_cnt_d = beat_cnt_q + 3'd1;
               end
            end
         end
         StWrite: begin
            serve_valid_d = 1'b1;
            state_d       = StServe;
         end
         StServe: begin
            if (serve_ready_i) begin
               serve_valid_d = 1'b0;
               busy_d        = 1'b0;
               state_d       = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign busy_o         = busy_q;
   assign mem_arvalid_o  = arvalid_q;
   assign mem_araddr_o   = araddr_q;
   assign mem_arlen_o    = 4'(LINE_BEATS - 1);
   assign mem_rready_o   = rready_q;
   assign wren_tag_o     = wren_q;
   assign waddr_tag_o    = waddr_q;
   assign wdata_tag_o    = wtag_q;
   assign wren_data_o    = wren_q;
   assign waddr_data_o   = waddr_q;
   assign wdata_data_o   = line_q;
   assign serve_valid_o  = serve_valid_q;
   assign serve_data_o   = serve_data_q;
   assign protocol_err_o = err_q;

endmodule

// File: tb/tb_cc_miss_refill.sv
// Directed bench for cc_miss_refill: table of refill scenarios plus a mid-burst reset.
module tb_cc_miss_refill;

   logic         clk;
   logic         rst_n;
   logic         miss_i;
   logic [16:0]  tag_i;
   logic [8:0]   index_i;
   logic [5:0]   offset_i;
   logic         busy_o;
   logic         mem_arvalid_o;
   logic         mem_arready_i;
   logic [31:0]  mem_araddr_o;
   logic [3:0]   mem_arlen_o;
   logic         mem_rvalid_i;
   logic         mem_rready_o;
   logic [63:0]  mem_rdata_i;
   logic         mem_rlast_i;
   logic         wren_tag_o;
   logic [8:0]   waddr_tag_o;
   logic [17:0]  wdata_tag_o;
   logic         wren_data_o;
   logic [8:0]   waddr_data_o;
   logic [511:0] wdata_data_o;
   logic         serve_valid_o;
   logic [63:0]  serve_data_o;
   logic         serve_ready_i;
   logic         protocol_err_o;

   cc_miss_refill dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .miss_i         (miss_i),
      .tag_i          (tag_i),
      .index_i        (index_i),
      .offset_i       (offset_i),
      .busy_o         (busy_o),
      .mem_arvalid_o  (mem_arvalid_o),
      .mem_arready_i  (mem_arready_i),
      .mem_araddr_o   (mem_araddr_o),
      .mem_arlen_o    (mem_arlen_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rready_o   (mem_rready_o),
      .mem_rdata_i    (mem_rdata_i),
      .mem_rlast_i    (mem_rlast_i),
      .wren_tag_o     (wren_tag_o),
      .waddr_tag_o    (waddr_tag_o),
      .wdata_tag_o    (wdata_tag_o),
      .wren_data_o    (wren_data_o),
      .waddr_data_o   (waddr_data_o),
      .wdata_data_o   (wdata_data_o),
      .serve_valid_o  (serve_valid_o),
      .serve_data_o   (serve_data_o),
      .serve_ready_i  (serve_ready_i),
      .protocol_err_o (protocol_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] tag;
      logic [8:0]  idx;
      logic [5:0]  off;
      int          ar_wait;
      logic [31:0] rv_pat;
      int          bad_beat;
      int          serve_wait;
      logic [31:0] extra;
      logic [31:0] araddr;
      logic [17:0] wtag;
      int          serve_beat;
      int          wr_cyc;
   } vec_t;

   vec_t        vecs[6];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rel_cyc;
   int          ar_cnt;
   int          wr_cnt;
   int          wr_cyc;
   logic [31:0] extra_mask;
   logic        err_exp;

   function automatic logic [63:0] bd(input int seed, input int k);
      return {16'h1111, seed[7:0], 8'h00, k[31:0]};
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; injects stray misses from extra_mask and counts AR handshakes / write pulses.
   task automatic step();
      if (rel_cyc < 32 && extra_mask[rel_cyc]) begin
         miss_i  = 1'b1;
         tag_i   = 17'h1DEAD;
         index_i = 9'h1EE;
      end
      if (mem_arvalid_o && mem_arready_i) ar_cnt++;
      @(posedge clk);
      #1;
      miss_i = 1'b0;
      rel_cyc++;
      if (wren_tag_o) begin
         wr_cnt++;
         wr_cyc = rel_cyc;
      end
   endtask

   function automatic logic [511:0] rst_outs();
      return 512'({busy_o, mem_arvalid_o, mem_araddr_o, mem_rready_o, wren_tag_o, waddr_tag_o,
                   wdata_tag_o, wren_data_o, waddr_data_o, serve_valid_o, serve_data_o,
                   protocol_err_o});
   endfunction

   task automatic refill(input vec_t v, input int seed);
      logic [511:0] line;
      int n;
      int b;
      int p;
      logic bad_now;
      for (int k = 0; k < 8; k++) line[k*64 +: 64] = bd(seed, k);
      rel_cyc    = 0;
      ar_cnt     = 0;
      wr_cnt     = 0;
      wr_cyc     = -1;
      extra_mask = v.extra;
      chk("idle_busy", 512'(busy_o), 512'(0));
      tag_i    = v.tag;
      index_i  = v.idx;
      offset_i = v.off;
      miss_i   = 1'b1;
      step();
      tag_i    = '0;
      index_i  = '0;
      offset_i = '0;
      chk("req_busy", 512'(busy_o), 512'(1));
      n = 0;
      while (mem_arvalid_o && n < 40) begin
         chk("araddr", 512'(mem_araddr_o), 512'(v.araddr));
         chk("arlen", 512'(mem_arlen_o), 512'(7));
         mem_arready_i = (n >= v.ar_wait);
         step();
         n++;
      end
      mem_arready_i = 1'b0;
      chk_int("ar_cycles", n, v.ar_wait + 1);
      b = 0;
      p = 0;
      while (b < 8 && p < 64) begin
         chk("rready", 512'(mem_rready_o), 512'(1));
         chk("err_fill", 512'(protocol_err_o), 512'(err_exp));
         mem_rvalid_i = (p < 32) ? v.rv_pat[p] : 1'b1;
         mem_rdata_i  = bd(seed, b);
         mem_rlast_i  = ((b == 7) != (b == v.bad_beat));
         bad_now      = mem_rvalid_i && (b == v.bad_beat);
         if (mem_rvalid_i) b++;
         step();
         if (bad_now) err_exp = 1'b1;
         p++;
      end
      mem_rvalid_i = 1'b0;
      mem_rlast_i  = 1'b0;
      chk_int("beats", b, 8);
      chk("wren_tag", 512'(wren_tag_o), 512'(1));
      chk("wren_data", 512'(wren_data_o), 512'(1));
      chk("waddr_tag", 512'(waddr_tag_o), 512'(v.idx));
      chk("waddr_data", 512'(waddr_data_o), 512'(v.idx));
      chk("wdata_tag", 512'(wdata_tag_o), 512'(v.wtag));
      chk("wdata_data", wdata_data_o, line);
      chk_int("wr_cycle", wr_cyc, v.wr_cyc);
      step();
      for (int s = 0; s <= v.serve_wait; s++) begin
         if (s == 0) chk_int("serve_cycle", rel_cyc, v.wr_cyc + 1);
         chk("serve_valid", 512'(serve_valid_o), 512'(1));
         chk("serve_data", 512'(serve_data_o), 512'(bd(seed, v.serve_beat)));
         chk("serve_busy", 512'(busy_o), 512'(1));
         serve_ready_i = (s == v.serve_wait);
         step();
      end
      serve_ready_i = 1'b0;
      chk("serve_done", 512'(serve_valid_o), 512'(0));
      chk("idle_after", 512'(busy_o), 512'(0));
      chk("araddr_hold", 512'(mem_araddr_o), 512'(v.araddr));
      chk("err_end", 512'(protocol_err_o), 512'(err_exp));
      chk_int("ar_accepts", ar_cnt, 1);
      chk_int("write_pulses", wr_cnt, 1);
      extra_mask = '0;
   endtask

   initial begin
      // tag, idx, off, ar_wait, rvalid pattern, bad rlast beat, serve_wait, stray misses,
      // araddr, wdata_tag, served beat, write-pulse cycle
      vecs[0] = '{17'h1A2B3, 9'h045, 6'h18, 0, 32'hFFFF_FFFF, 8, 0, 32'h0,
                  32'hD159_9140, 18'h3A2B3, 3, 10};
      vecs[1] = '{17'h00001, 9'h1FF, 6'h07, 5, 32'hFFFF_FFFF, 8, 4, 32'h0,
                  32'h0000_FFC0, 18'h20001, 0, 15};
      vecs[2] = '{17'h1FFFF, 9'h000, 6'h38, 0, 32'h0024_9249, 8, 0, 32'h0,
                  32'hFFFF_8000, 18'h3FFFF, 7, 24};
      vecs[3] = '{17'h0ABCD, 9'h123, 6'h10, 0, 32'hFFFF_FFFF, 8, 0, 32'h0000_0908,
                  32'h55E6_C8C0, 18'h2ABCD, 2, 10};
      vecs[4] = '{17'h12345, 9'h0AA, 6'h28, 0, 32'hFFFF_FFFF, 5, 0, 32'h0,
                  32'h91A2_AA80, 18'h32345, 5, 10};
      vecs[5] = '{17'h00F0F, 9'h055, 6'h00, 0, 32'hFFFF_FFFF, 8, 1, 32'h0,
                  32'h0787_9540, 18'h20F0F, 0, 10};

      rst_n         = 1'b0;
      miss_i        = 1'b0;
      tag_i         = '0;
      index_i       = '0;
      offset_i      = '0;
      mem_arready_i = 1'b0;
      mem_rvalid_i  = 1'b0;
      mem_rdata_i   = '0;
      mem_rlast_i   = 1'b0;
      serve_ready_i = 1'b0;
      extra_mask    = '0;
      rel_cyc       = 0;
      ar_cnt        = 0;
      wr_cnt        = 0;
      wr_cyc        = -1;
      err_exp       = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", rst_outs(), 512'(0));
      chk("reset_line", wdata_data_o, 512'(0));
      chk("reset_arlen", 512'(mem_arlen_o), 512'(7));
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 6; i++) refill(vecs[i], i);

      // Reset while beat 4 is on the bus: outputs clear without a clock edge, no SRAM write.
      rel_cyc  = 0;
      wr_cnt   = 0;
      tag_i    = 17'h01B00;
      index_i  = 9'h077;
      offset_i = 6'h20;
      miss_i   = 1'b1;
      step();
      mem_arready_i = 1'b1;
      step();
      mem_arready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = bd(9, k);
         step();
      end
      chk("pre_reset_busy", 512'(busy_o), 512'(1));
      mem_rdata_i = bd(9, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", rst_outs(), 512'(0));
      chk("async_reset_line", wdata_data_o, 512'(0));
      chk("async_reset_arlen", 512'(mem_arlen_o), 512'(7));
      mem_rvalid_i = 1'b0;
      repeat (3) step();
      chk_int("reset_no_write", wr_cnt, 0);
      rst_n   = 1'b1;
      err_exp = 1'b0;
      step();
      chk("post_reset_idle", 512'(busy_o), 512'(0));
      refill(vecs[0], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
